// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_driver
// Purpose  : Time-multiplexes a 16-bit, 4-nibble display word onto a 4-digit
//            common-anode 7-segment display. The word is captured into a
//            shadow register only at frame boundaries, so a digit never tears
//            mid-frame. Optional whole-display blink.
// Ports    : clk          - system clock, all state on rising edge
//            rst_n        - synchronous active-low reset
//            word_i       - display word {d3,d2,d1,d0}, d3 = leftmost
//            blink_en_i   - 1 = display alternates on/off every BLINK_FRAMES
//            an_o         - digit enables, active low, an_o[3] = leftmost
//            seg_o        - segments {g,f,e,d,c,b,a}, active low
//            dp_o         - decimal point, active low, always off
//            frame_done_o - 1-cycle pulse when the shadow word is captured
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_driver #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLINK_FRAMES = 125
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] word_i,
    input  logic        blink_en_i,
    output logic [3:0]  an_o,
    output logic [6:0]  seg_o,
    output logic        dp_o,
    output logic        frame_done_o
);

    localparam int PW = (REFRESH_DIV  > 1) ? $clog2(REFRESH_DIV)  : 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PW-1:0] c_presc_last = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] c_presc_one  = PW'(1);
    localparam logic [BW-1:0] c_blink_last = BW'(BLINK_FRAMES - 1);
    localparam logic [BW-1:0] c_blink_one  = BW'(1);

    typedef enum logic [0:0] {
        PH_ON  = 1'b0,
        PH_OFF = 1'b1
    } phase_t;

    logic [PW-1:0] presc_q,     presc_d;
    logic [1:0]    idx_q,       idx_d;
    logic [15:0]   shadow_q,    shadow_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    phase_t        phase_q,     phase_d;
    logic [3:0]    an_q,        an_d;
    logic [6:0]    seg_q,       seg_d;
    logic          dp_q,        dp_d;
    logic          fdone_q,     fdone_d;

    logic          tick;
    logic          boundary;
    logic [3:0]    nibble;

    // Active-low gfedcba patterns; 4'hF is the blank code.
    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] s;
        s = 7'h7F;
        case (n)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q     <= '0;
            idx_q       <= 2'd0;
            shadow_q    <= 16'hFFFF;
            blink_cnt_q <= '0;
            phase_q     <= PH_ON;
            an_q        <= 4'b1111;
            seg_q       <= 7'h7F;
            dp_q        <= 1'b1;
            fdone_q     <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            idx_q       <= idx_d;
            shadow_q    <= shadow_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            fdone_q     <= fdone_d;
        end
    end

    always_comb begin
        tick        = (presc_q == c_presc_last);
        boundary    = tick && (idx_q == 2'd3);
        presc_d     = tick ? '0 : (presc_q + c_presc_one);
        idx_d       = tick ? (idx_q + 2'd1) : idx_q;
        shadow_d    = boundary ? word_i : shadow_q;
        fdone_d     = boundary;
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        dp_d        = 1'b1;

        // Dropping blink_en restarts the blink cadence so the next enable
        // always gets a full ON phase first.
        if (!blink_en_i) begin
            blink_cnt_d = '0;
            phase_d     = PH_ON;
        end else if (boundary) begin
            if (blink_cnt_q == c_blink_last) begin
                blink_cnt_d = '0;
                phase_d     = (phase_q == PH_ON) ? PH_OFF : PH_ON;
            end else begin
                blink_cnt_d = blink_cnt_q + c_blink_one;
            end
        end

        // an and seg both derive from the same idx_q, so they move together.
        // phase_q can only be OFF while blinking is enabled.
        nibble = shadow_q[{idx_q, 2'b00} +: 4];
        seg_d  = decode(nibble);
        an_d   = (phase_q == PH_OFF) ? 4'b1111 : ~(4'b0001 << idx_q);
    end

    assign an_o         = an_q;
    assign seg_o        = seg_q;
    assign dp_o         = dp_q;
    assign frame_done_o = fdone_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_driver
// Purpose  : Directed self-checking bench for seg_scan_driver. Three
//            instances cover REFRESH_DIV = 4, 1 and 2 (the last with
//            BLINK_FRAMES = 2). Expected values are hand-derived.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan_driver;

    logic        clk;
    logic        rst_n;
    logic [15:0] word;
    logic        blink_c;
    logic        blink_off;

    logic [3:0] an_a, an_b, an_c;
    logic [6:0] seg_a, seg_b, seg_c;
    logic       dp_a, dp_b, dp_c;
    logic       fd_a, fd_b, fd_c;

    int checks = 0;
    int errors = 0;

    seg_scan_driver #(.REFRESH_DIV(4), .BLINK_FRAMES(2)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .word_i(word), .blink_en_i(blink_off),
        .an_o(an_a), .seg_o(seg_a), .dp_o(dp_a), .frame_done_o(fd_a));

    seg_scan_driver #(.REFRESH_DIV(1), .BLINK_FRAMES(125)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .word_i(word), .blink_en_i(blink_off),
        .an_o(an_b), .seg_o(seg_b), .dp_o(dp_b), .frame_done_o(fd_b));

    seg_scan_driver #(.REFRESH_DIV(2), .BLINK_FRAMES(2)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .word_i(word), .blink_en_i(blink_c),
        .an_o(an_c), .seg_o(seg_c), .dp_o(dp_c), .frame_done_o(fd_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges; returns at the following falling edge.
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reset all instances; returns at the negedge where rst_n goes high.
    task automatic do_reset(input logic [15:0] w, input logic be);
        rst_n = 1'b0;
        cyc(2);
        word    = w;
        blink_c = be;
        rst_n   = 1'b1;
    endtask

    task automatic test_reset;
        do_reset(16'h1A1F, 1'b0);
        checks++;
        if (an_a !== 4'b1111 || seg_a !== 7'h7F || dp_a !== 1'b1 || fd_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_vals: an=%b seg=%h dp=%b fd=%b, want 1111 7f 1 0", an_a, seg_a, dp_a, fd_a);
        end
        cyc(1);
        checks++;
        if (an_a !== 4'b1110 || seg_a !== 7'h7F) begin
            errors++;
            $display("FAIL first_digit: an=%b seg=%h, want 1110 7f", an_a, seg_a);
        end
        cyc(14);  // edge 15
        checks++;
        if (fd_a !== 1'b0) begin
            errors++;
            $display("FAIL fd_early: fd=%b, want 0", fd_a);
        end
        cyc(1);   // edge 16
        checks++;
        if (fd_a !== 1'b1 || an_a !== 4'b0111 || seg_a !== 7'h7F) begin
            errors++;
            $display("FAIL fd_16: fd=%b an=%b seg=%h, want 1 0111 7f", fd_a, an_a, seg_a);
        end
        cyc(1);   // edge 17
        checks++;
        if (fd_a !== 1'b0 || an_a !== 4'b1110 || seg_a !== 7'h7F) begin
            errors++;
            $display("FAIL f2_d0: fd=%b an=%b seg=%h, want 0 1110 7f", fd_a, an_a, seg_a);
        end
        cyc(4);   // edge 21
        checks++;
        if (an_a !== 4'b1101 || seg_a !== 7'h79) begin
            errors++;
            $display("FAIL f2_d1: an=%b seg=%h, want 1101 79", an_a, seg_a);
        end
        cyc(4);   // edge 25
        checks++;
        if (an_a !== 4'b1011 || seg_a !== 7'h08) begin
            errors++;
            $display("FAIL f2_d2: an=%b seg=%h, want 1011 08", an_a, seg_a);
        end
        cyc(4);   // edge 29
        checks++;
        if (an_a !== 4'b0111 || seg_a !== 7'h79) begin
            errors++;
            $display("FAIL f2_d3: an=%b seg=%h, want 0111 79", an_a, seg_a);
        end
    endtask

    task automatic test_midframe;
        do_reset(16'h1234, 1'b0);
        cyc(21);  // edge 21: d1 of '1234' showing
        checks++;
        if (seg_a !== 7'h30) begin
            errors++;
            $display("FAIL mf_d1: seg=%h, want 30", seg_a);
        end
        cyc(1);   // edge 22
        word = 16'h5678;
        cyc(3);   // edge 25
        checks++;
        if (seg_a !== 7'h24 || an_a !== 4'b1011) begin
            errors++;
            $display("FAIL mf_d2: an=%b seg=%h, want 1011 24", an_a, seg_a);
        end
        cyc(4);   // edge 29
        checks++;
        if (seg_a !== 7'h79 || fd_a !== 1'b0) begin
            errors++;
            $display("FAIL mf_d3: seg=%h fd=%b, want 79 0", seg_a, fd_a);
        end
        cyc(3);   // edge 32
        checks++;
        if (fd_a !== 1'b1) begin
            errors++;
            $display("FAIL mf_fd: fd=%b, want 1", fd_a);
        end
        cyc(1);   // edge 33
        checks++;
        if (seg_a !== 7'h00 || an_a !== 4'b1110) begin
            errors++;
            $display("FAIL mf_new_d0: an=%b seg=%h, want 1110 00", an_a, seg_a);
        end
        cyc(4);   // edge 37
        checks++;
        if (seg_a !== 7'h78) begin
            errors++;
            $display("FAIL mf_new_d1: seg=%h, want 78", seg_a);
        end
    endtask

    task automatic test_refresh1;
        logic [3:0] exp_an;
        logic       exp_fd;
        do_reset(16'hFFFF, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            cyc(1);
            exp_an = ~(4'b0001 << ((k - 1) % 4));
            exp_fd = ((k % 4) == 0);
            checks++;
            if (an_b !== exp_an || fd_b !== exp_fd) begin
                errors++;
                $display("FAIL rd1_cyc%0d: an=%b fd=%b, want %b %b", k, an_b, fd_b, exp_an, exp_fd);
            end
        end
    endtask

    task automatic test_blink;
        do_reset(16'h1234, 1'b1);
        cyc(16);
        checks++;
        if (an_c !== 4'b0111) begin
            errors++;
            $display("FAIL bl_f2_end: an=%b, want 0111", an_c);
        end
        cyc(1);   // edge 17: frame 3 blanked, seg still decodes
        checks++;
        if (an_c !== 4'b1111 || seg_c !== 7'h19) begin
            errors++;
            $display("FAIL bl_f3: an=%b seg=%h, want 1111 19", an_c, seg_c);
        end
        cyc(15);  // edge 32
        checks++;
        if (an_c !== 4'b1111) begin
            errors++;
            $display("FAIL bl_f4_end: an=%b, want 1111", an_c);
        end
        cyc(1);   // edge 33
        checks++;
        if (an_c !== 4'b1110) begin
            errors++;
            $display("FAIL bl_f5: an=%b, want 1110", an_c);
        end
        cyc(17);  // edge 50, OFF again
        checks++;
        if (an_c !== 4'b1111) begin
            errors++;
            $display("FAIL bl_f7: an=%b, want 1111", an_c);
        end
        blink_c = 1'b0;
        cyc(1);   // edge 51
        checks++;
        if (an_c !== 4'b1111) begin
            errors++;
            $display("FAIL bl_drop1: an=%b, want 1111", an_c);
        end
        cyc(1);   // edge 52
        checks++;
        if (an_c !== 4'b1101) begin
            errors++;
            $display("FAIL bl_drop2: an=%b, want 1101", an_c);
        end
    endtask

    task automatic test_reset_midframe;
        do_reset(16'h1234, 1'b1);
        cyc(20);  // idx=2, phase OFF
        checks++;
        if (an_c !== 4'b1111) begin
            errors++;
            $display("FAIL rm_pre: an=%b, want 1111", an_c);
        end
        rst_n = 1'b0;
        cyc(1);
        checks++;
        if (an_c !== 4'b1111 || seg_c !== 7'h7F || dp_c !== 1'b1 || fd_c !== 1'b0) begin
            errors++;
            $display("FAIL rm_vals: an=%b seg=%h dp=%b fd=%b, want 1111 7f 1 0", an_c, seg_c, dp_c, fd_c);
        end
        rst_n = 1'b1;
        cyc(1);
        checks++;
        if (an_c !== 4'b1110 || seg_c !== 7'h7F) begin
            errors++;
            $display("FAIL rm_restart: an=%b seg=%h, want 1110 7f", an_c, seg_c);
        end
    endtask

    task automatic test_decode;
        logic [6:0] tbl [16];
        tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h7F};
        do_reset(16'hFFF0, 1'b0);
        cyc(5);
        for (int v = 0; v < 16; v++) begin
            checks++;
            if (seg_b !== tbl[v] || an_b !== 4'b1110) begin
                errors++;
                $display("FAIL dec_%h: an=%b seg=%h, want 1110 %h", v[3:0], an_b, seg_b, tbl[v]);
            end
            word = {12'hFFF, 4'(v + 1)};
            cyc(4);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        word      = 16'hFFFF;
        blink_c   = 1'b0;
        blink_off = 1'b0;
        test_reset;
        test_midframe;
        test_refresh1;
        test_blink;
        test_reset_midframe;
        test_decode;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
